uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
Sits directly downstream of the UART receiver. It consumes the one-cycle valid/byte stream and assembles command frames of the form SYNC, CMD, LEN, PAYLOAD[LEN], CSUM. Frames that check good are committed to registered outputs for the flight-control logic. Bad frames are dropped and counted.

Parameters:
MAX_LEN, 8, maximum payload bytes; LEN > MAX_LEN is a framing error.
TIMEOUT_CLKS, 50000, maximum clocks allowed between bytes inside a frame before the frame is abandoned.
SYNC_BYTE, 8'hA5, start-of-frame marker.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
i_Rx_Valid  input  1  one-cycle strobe from the UART receiver; byte present on i_Rx_Data.
i_Rx_Data  input  8  received byte, sampled only when i_Rx_Valid=1.
i_Err_Clr  input  1  synchronous clear of o_Err_Count.
o_Frame_Valid  output  1  one-cycle pulse when a good frame is committed.
o_Cmd  output  8  command ID of the last good frame.
o_Len  output  8  payload length of the last good frame.
o_Payload  output  8*MAX_LEN  payload of the last good frame; byte k is at bits [8k+7:8k]; unused bytes are 0.
o_Err  output  1  one-cycle pulse when a frame is dropped.
o_Err_Code  output  2  reason for the last drop: 1 = bad length, 2 = bad checksum, 3 = timeout.
o_Err_Count  output  8  saturating count of dropped frames.

Behaviour:
- Reset (async assert, sync release):
  - State is HUNT.
  - All outputs are 0, including o_Payload.
  - Shadow buffer, byte index, running checksum and timeout counter are 0.
- Checksum: XOR of CMD, LEN and every payload byte. SYNC is excluded. The frame is good when the running XOR equals CSUM.
- FSM:
  - HUNT: on a valid byte equal to SYNC_BYTE, go to GET_CMD. Any other byte is ignored silently, with no error.
  - GET_CMD: on a valid byte, latch CMD, seed the running XOR with it, go to GET_LEN.
  - GET_LEN: on a valid byte:
    - if the byte > MAX_LEN: error code 1, go to HUNT.
    - else latch LEN, XOR it in, clear the index, clear the shadow buffer.
    - go to GET_CSUM if LEN=0, else GET_PAYLOAD.
  - GET_PAYLOAD: on a valid byte:
    - shadow[index] <= byte; XOR it in.
    - when index = LEN-1, go to GET_CSUM; else increment the index.
  - GET_CSUM: on a valid byte, go to HUNT. On match, commit; on mismatch, error code 2.
- Commit: registered. On the clock edge after the CSUM byte's valid cycle:
  - o_Frame_Valid=1 for exactly one cycle.
  - o_Cmd, o_Len and o_Payload (copied from the shadow buffer) update on that same edge.
  - Outputs hold their values until the next good frame. Bad frames never disturb them.
- Timeout:
  - The counter runs in every state except HUNT and is zeroed by every valid byte.
  - When the counter reaches TIMEOUT_CLKS-1 with no byte present: error code 3, go to HUNT.
  - A valid byte arriving in the same cycle as expiry wins: it is processed and no timeout occurs.
- Error:
  - o_Err pulses for one cycle, registered, aligned the same way as o_Frame_Valid.
  - o_Err_Code updates on the same edge and holds until the next error.
  - o_Err_Count increments and saturates at 255.
- i_Err_Clr: the count becomes 0. If an error occurs in the same cycle, the count becomes 1.
- SYNC_BYTE seen after HUNT is treated as ordinary data. There is no mid-frame resync.
- i_Rx_Valid is at most one cycle wide, and bytes are at least 2 clocks apart. The block need not handle back-to-back valid.
- Reset asserted mid-frame: the partial frame is discarded silently. Outputs clear and o_Err_Count is zeroed.

Decomposition:
- Shared package holds:
  - the FSM state encodings HUNT=0, GET_CMD=1, GET_LEN=2, GET_PAYLOAD=3, GET_CSUM=4;
  - the error codes ERR_LEN=1, ERR_CSUM=2, ERR_TIMEOUT=3;
  - the default SYNC_BYTE.
- One sub-module is natural: uart_byte_timeout. It contains the counter, with inputs clear, enable and byte strobe, and a single-cycle expire output.
- Frame FSM, shadow buffer and commit logic stay in uart_cmd_parser.

Test Plan:
1. Send A5 10 02 33 44 65 -> one cycle after the 65 strobe: o_Frame_Valid=1, o_Cmd=10, o_Len=2, o_Payload[15:0]=4433, upper bytes 0; o_Err stays 0.
2. Send A5 20 00 20 (zero-length frame) -> o_Frame_Valid=1, o_Cmd=20, o_Len=0, o_Payload=0.
3. Send A5 10 02 33 44 66 (bad checksum) -> o_Err=1, o_Err_Code=2, o_Err_Count=1; o_Cmd, o_Len and o_Payload keep the values from scenario 1.
4. Send A5 10 09 (LEN > MAX_LEN), then A5 11 01 55 45 -> the first frame gives o_Err_Code=1; the second frame is accepted with o_Cmd=11 and o_Payload[7:0]=55.
5. Send A5 10 then idle for TIMEOUT_CLKS clocks -> o_Err pulses once with o_Err_Code=3, state is HUNT; a byte strobed exactly at expiry produces no timeout.
6. Force 256 bad frames -> o_Err_Count=255; pulse i_Err_Clr in the same cycle as an error -> count=1; assert rst_n=0 mid-payload -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command-frame parser.
//   state_t     : frame FSM state encodings
//   err_code_t  : drop-reason codes reported on o_Err_Code
//   SYNC_BYTE_DEF : default start-of-frame marker
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    HUNT        = 3'd0,
    GET_CMD     = 3'd1,
    GET_LEN     = 3'd2,
    GET_PAYLOAD = 3'd3,
    GET_CSUM    = 3'd4
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_LEN     = 2'd1;
  localparam err_code_t ERR_CSUM    = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte timeout counter for the command parser.
//   clk, rst_n : clock, async active-low reset
//   clear      : hold the counter at zero (parser idle)
//   enable     : count clocks while a frame is open
//   byte_stb   : a byte arrived this cycle; restarts the count and vetoes expiry
//   expire     : single-cycle pulse, TIMEOUT_CLKS clocks after the last byte
module uart_byte_timeout #(
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic byte_stb,
  output logic expire
);

  localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q;

  // A byte in the expiry cycle wins over the timeout.
  assign expire = enable && !byte_stb && (cnt_q == TC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || byte_stb || expire) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: SYNC, CMD, LEN, PAYLOAD[LEN], CSUM.
// Good frames are committed to registered outputs; bad frames are dropped,
// reported and counted.
//   clk, rst_n     : clock, async active-low reset
//   i_Rx_Valid/Data: one-cycle byte strobe from the UART receiver
//   i_Err_Clr      : synchronous clear of o_Err_Count
//   o_Frame_Valid  : one-cycle pulse on commit of a good frame
//   o_Cmd/Len/Payload : last good frame (payload byte k at [8k+7:8k])
//   o_Err, o_Err_Code, o_Err_Count : drop pulse, reason, saturating count
//
// state       | meaning
// ------------+-----------------------------------------------
// HUNT        | idle, waiting for SYNC_BYTE
// GET_CMD     | next byte is the command ID
// GET_LEN     | next byte is payload length
// GET_PAYLOAD | collecting payload into the shadow buffer
// GET_CSUM    | next byte is the checksum; commit or drop
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 50000,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_Rx_Valid,
  input  logic [7:0]           i_Rx_Data,
  input  logic                 i_Err_Clr,
  output logic                 o_Frame_Valid,
  output logic [7:0]           o_Cmd,
  output logic [7:0]           o_Len,
  output logic [8*MAX_LEN-1:0] o_Payload,
  output logic                 o_Err,
  output logic [1:0]           o_Err_Code,
  output logic [7:0]           o_Err_Count
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t               state_q;
  logic [7:0]           cmd_q;
  logic [7:0]           len_q;
  logic [7:0]           idx_q;
  logic [7:0]           xor_q;
  logic [8*MAX_LEN-1:0] shadow_q;

  logic      tmo_expire;
  logic      err_fire;
  logic      commit_fire;
  err_code_t err_code_d;

  uart_byte_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == HUNT),
    .enable  (state_q != HUNT),
    .byte_stb(i_Rx_Valid),
    .expire  (tmo_expire)
  );

  // Frame outcome for this cycle; feeds the registered pulses and counter.
  always_comb begin
    err_fire    = 1'b0;
    err_code_d  = ERR_NONE;
    commit_fire = 1'b0;
    if (i_Rx_Valid) begin
      case (state_q)
        GET_LEN: begin
          if (i_Rx_Data > MAX_LEN_B) begin
            err_fire   = 1'b1;
            err_code_d = ERR_LEN;
          end
        end
        GET_CSUM: begin
          if (i_Rx_Data == xor_q) begin
            commit_fire = 1'b1;
          end else begin
            err_fire   = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end else if (tmo_expire) begin
      err_fire   = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      cmd_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      xor_q         <= '0;
      shadow_q      <= '0;
      o_Frame_Valid <= 1'b0;
      o_Cmd         <= '0;
      o_Len         <= '0;
      o_Payload     <= '0;
      o_Err         <= 1'b0;
      o_Err_Code    <= '0;
      o_Err_Count   <= '0;
    end else begin
      o_Frame_Valid <= commit_fire;
      o_Err         <= err_fire;

      if (commit_fire) begin
        o_Cmd     <= cmd_q;
        o_Len     <= len_q;
        o_Payload <= shadow_q;
      end

      if (err_fire) begin
        o_Err_Code <= err_code_d;
      end

      // Clear has priority but still records a coincident error.
      if (i_Err_Clr) begin
        o_Err_Count <= {7'd0, err_fire};
      end else if (err_fire && (o_Err_Count != 8'hFF)) begin
        o_Err_Count <= o_Err_Count + 8'd1;
      end

      if (i_Rx_Valid) begin
        case (state_q)
          HUNT: begin
            if (i_Rx_Data == SYNC_BYTE) state_q <= GET_CMD;
          end
          GET_CMD: begin
            cmd_q   <= i_Rx_Data;
            xor_q   <= i_Rx_Data;
            state_q <= GET_LEN;
          end
          GET_LEN: begin
            if (i_Rx_Data > MAX_LEN_B) begin
              state_q <= HUNT;
            end else begin
              len_q    <= i_Rx_Data;
              xor_q    <= xor_q ^ i_Rx_Data;
              idx_q    <= '0;
              shadow_q <= '0;
              state_q  <= (i_Rx_Data == 8'd0) ? GET_CSUM : GET_PAYLOAD;
            end
          end
          GET_PAYLOAD: begin
            for (int k = 0; k < MAX_LEN; k++) begin
              if (idx_q == 8'(k)) shadow_q[8*k +: 8] <= i_Rx_Data;
            end
            xor_q <= xor_q ^ i_Rx_Data;
            if (idx_q == len_q - 8'd1) begin
              state_q <= GET_CSUM;
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end
          GET_CSUM: begin
            state_q <= HUNT;
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end else if (tmo_expire) begin
        state_q <= HUNT;
      end
    end
  end

endmodule
